rom_guess_ctrl: RTL and testbench
=================================

ROM_GUESS_CTRL -- requirements
Module: rom_guess_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, ROM address width; ROM depth 2**ADDR_W entries.
REQ-002 Parameter MAX_TRIES, default 3, wrong guesses allowed per entry (1..15).
REQ-003 Parameter SHOW_CYC, default 4, cycles a round result is held (>=1).
REQ-004 iClk  in  1  single clock; all state changes on rising edge.
REQ-005 iRst  in  1  reset, synchronous, active-high.
REQ-006 iSW  in  8  player guess (switches), synchronous to iClk.
REQ-007 iGo  in  1  player button, synchronous, level; only rising edges act.
REQ-008 oAddr  out  ADDR_W  ROM read address.
REQ-009 iData  in  8  ROM data; valid one cycle after oAddr changes.
REQ-010 oHit / oMiss  out  1 each  round result flags, valid in SHOW only.
REQ-011 oHigh / oLow  out  1 each  hint: last wrong guess above/below target.
REQ-012 oRU / oRD  out  4 each  score BCD units/tens, to downstream 7-segment decoders.
REQ-013 oDone  out  1  all ROM entries played.

Function
REQ-014 Edge detect: go_edge = iGo & ~iGo_prev (iGo_prev registered); go_edge outside IDLE/WAIT/DONE is discarded, not queued.
REQ-015 States: IDLE, FETCH, WAIT, CMP, SHOW, DONE.
REQ-016 IDLE: oAddr=0, score held; go_edge -> FETCH.
REQ-017 FETCH: exactly 2 cycles, oAddr stable; on the 2nd cycle iData latched into target, tries cleared -> WAIT.
REQ-018 WAIT: go_edge captures iSW into guess -> CMP.
REQ-019 CMP (1 cycle): guess==target -> score+1, hints cleared, -> SHOW with hit; else tries+1, oHigh=(guess>target), oLow=(guess<target); if tries+1==MAX_TRIES -> SHOW with miss, else -> WAIT.
REQ-020 SHOW: oHit or oMiss high for exactly SHOW_CYC cycles; then oAddr==2**ADDR_W-1 -> DONE, else oAddr+1 -> FETCH.
REQ-021 DONE: oDone=1, score held; go_edge -> score=00, oAddr=0, hints cleared -> FETCH.
REQ-022 Score two-digit BCD; units 9->0 with tens+1; saturates at 99 (further hits leave 99).
REQ-023 oHigh/oLow mutually exclusive; hold until next CMP or leaving SHOW.
REQ-024 Comparison unsigned 8-bit.
REQ-025 All outputs registered; no combinational input-to-output path.

Reset
REQ-026 iRst high at any edge, any state: state=IDLE, oAddr=0, oRU=oRD=0, oHit=oMiss=oHigh=oLow=oDone=0, tries=0, target=guess=0, iGo_prev=1 (button held across reset produces no edge).
REQ-027 Reset has priority over go_edge in the same cycle.

Structure
REQ-028 Shared package practice_pkg holds the state enum, 4-bit BCD digit typedef, and defaults for ADDR_W, MAX_TRIES, SHOW_CYC.
REQ-029 One sub-module bcd_counter2: synchronous clear, increment enable, saturating 00..99, outputs units/tens.
REQ-030 ROM and 7-segment decoders are external; this block only drives oAddr and oRU/oRD.

Verification
REQ-031 ROM[0]=0x2A; reset, go, iSW=0x2A, go -> oHit high 4 cycles, oRU=1 oRD=0, oAddr=1 in FETCH.
REQ-032 ROM[0]=0x50; guesses 0x60, 0x10, 0x20 -> oHigh, then oLow, oLow, then oMiss 4 cycles, score 00, oAddr=1.
REQ-033 ROM all 0x07, always guess 0x07, ADDR_W=4 -> after 16 rounds oDone=1, oRD=1 oRU=6; go -> score 00, oAddr=0, FETCH.
REQ-034 Force score 99 (ADDR_W=7, 110 hits) -> oRD=9 oRU=9 held after hits 100..110.
REQ-035 go pulses during FETCH, CMP, SHOW ignored; iRst asserted in WAIT with iGo high -> all outputs zero, IDLE, no FETCH until iGo released and pressed again.

Source files
------------

// File: rtl/practice_pkg.sv
// Shared types and parameter defaults for the ROM guessing game controller.
// No logic and no latency; declarations only.
package practice_pkg;

  localparam int ADDR_W_DEF    = 4;
  localparam int MAX_TRIES_DEF = 3;
  localparam int SHOW_CYC_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_CMP,
    ST_SHOW,
    ST_DONE
  } state_e;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score counter, saturating at 99, with synchronous clear.
// Registered outputs update one cycle after clr_i/inc_i; no backpressure.
module bcd_counter2
  import practice_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output bcd_t units_o,
  output bcd_t tens_o
);

  bcd_t units_q, units_d;
  bcd_t tens_q, tens_d;

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (clr_i) begin
      units_d = '0;
      tens_d  = '0;
    end else if (inc_i && !(units_q == 4'd9 && tens_q == 4'd9)) begin
      if (units_q == 4'd9) begin
        units_d = '0;
        tens_d  = tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      units_q <= '0;
      tens_q  <= '0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
    end
  end

  assign units_o = units_q;
  assign tens_o  = tens_q;

endmodule

// File: rtl/rom_guess_ctrl.sv
// Guessing game: walks an external ROM, compares player guesses, keeps a BCD score.
// ROM data is taken on the 2nd FETCH cycle; go presses outside IDLE/WAIT/DONE are dropped.
module rom_guess_ctrl
  import practice_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF,
  parameter int SHOW_CYC  = SHOW_CYC_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [7:0]        iSW,
  input  logic              iGo,
  output logic [ADDR_W-1:0] oAddr,
  input  logic [7:0]        iData,
  output logic              oHit,
  output logic              oMiss,
  output logic              oHigh,
  output logic              oLow,
  output bcd_t              oRU,
  output bcd_t              oRD,
  output logic              oDone
);

  localparam int                SHOW_W    = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYC - 1);
  localparam logic [3:0]        MAX_T     = 4'(MAX_TRIES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e              state_q, state_d;
  logic                go_prev_q;
  logic                fetch_q, fetch_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          target_q, target_d;
  logic [7:0]          guess_q, guess_d;
  logic [3:0]          tries_q, tries_d;
  logic [SHOW_W-1:0]   show_q, show_d;
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;
  logic                high_q, high_d;
  logic                low_q, low_d;
  logic                done_q, done_d;
  logic                score_clr, score_inc;
  logic                go_edge;
  logic [3:0]          tries_inc;

  assign go_edge   = iGo & ~go_prev_q;
  assign tries_inc = tries_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    fetch_d   = fetch_q;
    addr_d    = addr_q;
    target_d  = target_q;
    guess_d   = guess_q;
    tries_d   = tries_q;
    show_d    = show_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    high_d    = high_q;
    low_d     = low_q;
    done_d    = done_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (go_edge) begin
          fetch_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // ROM is one cycle behind oAddr, so the second cycle carries valid data
        if (fetch_q) begin
          target_d = iData;
          tries_d  = '0;
          fetch_d  = 1'b0;
          state_d  = ST_WAIT;
        end else begin
          fetch_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (go_edge) begin
          guess_d = iSW;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (guess_q == target_q) begin
          score_inc = 1'b1;
          high_d    = 1'b0;
          low_d     = 1'b0;
          hit_d     = 1'b1;
          show_d    = '0;
          state_d   = ST_SHOW;
        end else begin
          tries_d = tries_inc;
          high_d  = guess_q > target_q;
          low_d   = guess_q < target_q;
          if (tries_inc == MAX_T) begin
            miss_d  = 1'b1;
            show_d  = '0;
            state_d = ST_SHOW;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_SHOW: begin
        if (show_q == SHOW_LAST) begin
          hit_d  = 1'b0;
          miss_d = 1'b0;
          high_d = 1'b0;
          low_d  = 1'b0;
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            fetch_d = 1'b0;
            state_d = ST_FETCH;
          end
        end else begin
          show_d = show_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (go_edge) begin
          score_clr = 1'b1;
          addr_d    = '0;
          high_d    = 1'b0;
          low_d     = 1'b0;
          done_d    = 1'b0;
          fetch_d   = 1'b0;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // go_prev resets high so a button held through reset is not seen as a press
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      go_prev_q <= 1'b1;
      fetch_q   <= 1'b0;
      addr_q    <= '0;
      target_q  <= '0;
      guess_q   <= '0;
      tries_q   <= '0;
      show_q    <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      high_q    <= 1'b0;
      low_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_prev_q <= iGo;
      fetch_q   <= fetch_d;
      addr_q    <= addr_d;
      target_q  <= target_d;
      guess_q   <= guess_d;
      tries_q   <= tries_d;
      show_q    <= show_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      high_q    <= high_d;
      low_q     <= low_d;
      done_q    <= done_d;
    end
  end

  bcd_counter2 u_score (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .units_o (oRU),
    .tens_o  (oRD)
  );

  assign oAddr = addr_q;
  assign oHit  = hit_q;
  assign oMiss = miss_q;
  assign oHigh = high_q;
  assign oLow  = low_q;
  assign oDone = done_q;

endmodule

// File: tb/tb_rom_guess_ctrl.sv
// Bench for rom_guess_ctrl: game-level reference model (scores, hints, rounds) against two DUT sizes.
module tb_rom_guess_ctrl;

  localparam int MAXT  = 3;
  localparam int SHOWC = 4;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iGo;
  logic [7:0] iSW;
  always #5 iClk = ~iClk;

  logic [7:0] data_a, data_b;
  logic [3:0] addr_a;
  logic [6:0] addr_b;
  logic       hit_a, miss_a, high_a, low_a, done_a;
  logic       hit_b, miss_b, high_b, low_b, done_b;
  logic [3:0] ru_a, rd_a, ru_b, rd_b;

  rom_guess_ctrl #(.ADDR_W(4), .MAX_TRIES(MAXT), .SHOW_CYC(SHOWC)) u_a (
    .iClk(iClk), .iRst(iRst), .iSW(iSW), .iGo(iGo), .oAddr(addr_a), .iData(data_a),
    .oHit(hit_a), .oMiss(miss_a), .oHigh(high_a), .oLow(low_a), .oRU(ru_a), .oRD(rd_a),
    .oDone(done_a));

  rom_guess_ctrl #(.ADDR_W(7), .MAX_TRIES(MAXT), .SHOW_CYC(SHOWC)) u_b (
    .iClk(iClk), .iRst(iRst), .iSW(iSW), .iGo(iGo), .oAddr(addr_b), .iData(data_b),
    .oHit(hit_b), .oMiss(miss_b), .oHigh(high_b), .oLow(low_b), .oRU(ru_b), .oRD(rd_b),
    .oDone(done_b));

  logic [7:0] rom_a [16];
  logic [7:0] rom_b [128];
  always @(posedge iClk) begin
    data_a <= rom_a[addr_a];
    data_b <= rom_b[addr_b];
  end

  bit         sel;
  logic       o_hit, o_miss, o_high, o_low, o_done;
  logic [3:0] o_ru, o_rd;
  logic [6:0] o_addr;
  assign o_hit  = sel ? hit_b  : hit_a;
  assign o_miss = sel ? miss_b : miss_a;
  assign o_high = sel ? high_b : high_a;
  assign o_low  = sel ? low_b  : low_a;
  assign o_done = sel ? done_b : done_a;
  assign o_ru   = sel ? ru_b   : ru_a;
  assign o_rd   = sel ? rd_b   : rd_a;
  assign o_addr = sel ? addr_b : {3'b000, addr_a};

  int         checks = 0;
  int         errors = 0;
  int         m_score;
  int         m_addr;
  bit         rand_guess;
  logic [7:0] gq [$];

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic press();
    iGo = 1'b1;
    tick();
    iGo = 1'b0;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    iGo  = 1'b0;
    iSW  = 8'h00;
    tick();
    tick();
    iRst = 1'b0;
    tick();
    m_score = 0;
    m_addr  = 0;
    gq.delete();
    rand_guess = 1'b0;
  endtask

  // Plays one ROM entry; assumes the round's FETCH has started already.
  task automatic run_round(input bit pulse_show);
    logic [7:0] t, g;
    int tries, cnt, last;
    bit res, hit;
    last  = sel ? 127 : 15;
    t     = sel ? rom_b[m_addr] : rom_a[m_addr];
    tries = 0;
    res   = 1'b0;
    hit   = 1'b0;
    repeat (3) tick();
    while (!res && tries < MAXT) begin
      if (gq.size() > 0) g = gq.pop_front();
      else if (!rand_guess) return;
      else g = ($urandom_range(0, 2) == 0) ? t : 8'($urandom_range(0, 255));
      iSW = g;
      press();
      tick();
      if (g == t) begin
        hit = 1'b1;
        res = 1'b1;
        m_score = (m_score < 99) ? m_score + 1 : 99;
      end else begin
        tries++;
        res = (tries == MAXT);
      end
      checks++;
      if ({o_high, o_low} !== {g > t, g < t}) begin
        errors++;
        $display("FAIL hints addr=%0d guess=%h target=%h got hi/lo=%b%b want %b%b",
                 m_addr, g, t, o_high, o_low, g > t, g < t);
      end
      checks++;
      if ({o_rd, o_ru} !== {4'(m_score / 10), 4'(m_score % 10)}) begin
        errors++;
        $display("FAIL score addr=%0d got %0d%0d want %0d", m_addr, o_rd, o_ru, m_score);
      end
      if (!res) begin
        checks++;
        if ({o_hit, o_miss} !== 2'b00) begin
          errors++;
          $display("FAIL early_result addr=%0d got hit/miss=%b%b want 00", m_addr, o_hit, o_miss);
        end
      end
    end
    if (!res) return;
    checks++;
    if ({o_hit, o_miss} !== {hit, !hit}) begin
      errors++;
      $display("FAIL result addr=%0d got hit/miss=%b%b want %b%b", m_addr, o_hit, o_miss, hit, !hit);
    end
    cnt = 0;
    while ((o_hit | o_miss) && cnt < 40) begin
      cnt++;
      if (pulse_show && cnt == 2) iGo = 1'b1;
      if (cnt == 3) iGo = 1'b0;
      tick();
    end
    iGo = 1'b0;
    checks++;
    if (cnt != SHOWC) begin
      errors++;
      $display("FAIL show_len addr=%0d got %0d cycles want %0d", m_addr, cnt, SHOWC);
    end
    checks++;
    if ({o_high, o_low} !== 2'b00) begin
      errors++;
      $display("FAIL hints_after_show got %b%b want 00", o_high, o_low);
    end
    checks++;
    if (m_addr == last) begin
      if (o_done !== 1'b1) begin
        errors++;
        $display("FAIL done got %b want 1", o_done);
      end
    end else begin
      m_addr++;
      if (o_addr !== 7'(m_addr) || o_done !== 1'b0) begin
        errors++;
        $display("FAIL next_addr got addr=%0d done=%b want addr=%0d done=0", o_addr, o_done, m_addr);
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    checks++;
    if ({addr_a, ru_a, rd_a, hit_a, miss_a, high_a, low_a, done_a} !== '0) begin
      errors++;
      $display("FAIL reset_a got addr=%0d ru=%0d rd=%0d flags=%b%b%b%b%b want all 0",
               addr_a, ru_a, rd_a, hit_a, miss_a, high_a, low_a, done_a);
    end
    checks++;
    if ({addr_b, ru_b, rd_b, hit_b, miss_b, high_b, low_b, done_b} !== '0) begin
      errors++;
      $display("FAIL reset_b got addr=%0d ru=%0d rd=%0d flags=%b%b%b%b%b want all 0",
               addr_b, ru_b, rd_b, hit_b, miss_b, high_b, low_b, done_b);
    end
  endtask

  task automatic test_hit();
    sel = 1'b0;
    rom_a[0] = 8'h2A;
    rom_a[1] = 8'h00;
    do_reset();
    press();
    gq.push_back(8'h2A);
    run_round(1'b0);
  endtask

  task automatic test_miss();
    sel = 1'b0;
    rom_a[0] = 8'h50;
    do_reset();
    press();
    gq.push_back(8'h60);
    gq.push_back(8'h10);
    gq.push_back(8'h20);
    run_round(1'b0);
  endtask

  task automatic test_full_game();
    sel = 1'b0;
    for (int i = 0; i < 16; i++) rom_a[i] = 8'h07;
    do_reset();
    press();
    repeat (16) begin
      gq.push_back(8'h07);
      run_round(1'b0);
    end
    checks++;
    if ({o_done, o_rd, o_ru} !== {1'b1, 4'd1, 4'd6}) begin
      errors++;
      $display("FAIL game_end got done=%b score=%0d%0d want done=1 score=16", o_done, o_rd, o_ru);
    end
    press();
    m_score = 0;
    m_addr  = 0;
    checks++;
    if ({o_done, o_rd, o_ru, o_addr} !== '0) begin
      errors++;
      $display("FAIL restart got done=%b score=%0d%0d addr=%0d want all 0", o_done, o_rd, o_ru, o_addr);
    end
    gq.push_back(8'h07);
    run_round(1'b0);
  endtask

  task automatic test_random_game();
    sel = 1'b0;
    for (int i = 0; i < 16; i++) rom_a[i] = 8'($urandom_range(0, 255));
    rom_a[3] = 8'h00;
    rom_a[4] = 8'hFF;
    do_reset();
    rand_guess = 1'b1;
    press();
    repeat (16) run_round(1'b0);
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL random_done got %b want 1", o_done);
    end
  endtask

  task automatic test_ignored_go();
    sel = 1'b0;
    rom_a[0] = 8'h3C;
    rom_a[1] = 8'h3C;
    do_reset();
    iSW = 8'h3C;
    press();
    tick();
    iGo = 1'b1;
    tick();
    iGo = 1'b0;
    repeat (4) tick();
    checks++;
    if ({o_hit, o_miss, o_high, o_low} !== 4'b0000) begin
      errors++;
      $display("FAIL fetch_go got flags=%b%b%b%b want 0000", o_hit, o_miss, o_high, o_low);
    end
    gq.push_back(8'h3C);
    run_round(1'b1);
    repeat (6) tick();
    checks++;
    if ({o_hit, o_miss} !== 2'b00) begin
      errors++;
      $display("FAIL show_go got hit/miss=%b%b want 00", o_hit, o_miss);
    end
    gq.push_back(8'h3C);
    m_addr = 1;
    m_addr = m_addr;
    run_round(1'b0);
  endtask

  task automatic test_reset_in_wait();
    sel = 1'b0;
    rom_a[0] = 8'h11;
    rom_a[1] = 8'h40;
    do_reset();
    press();
    gq.push_back(8'h11);
    run_round(1'b0);
    gq.push_back(8'h99);
    run_round(1'b0);
    iGo  = 1'b1;
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    repeat (4) tick();
    checks++;
    if ({o_addr, o_ru, o_rd, o_hit, o_miss, o_high, o_low, o_done} !== '0) begin
      errors++;
      $display("FAIL wait_reset got addr=%0d score=%0d%0d flags=%b%b%b%b%b want all 0",
               o_addr, o_rd, o_ru, o_hit, o_miss, o_high, o_low, o_done);
    end
    iGo = 1'b0;
    tick();
    m_score = 0;
    m_addr  = 0;
    iSW = 8'h11;
    press();
    repeat (4) tick();
    checks++;
    if ({o_hit, o_miss} !== 2'b00) begin
      errors++;
      $display("FAIL held_go_start got hit/miss=%b%b want 00", o_hit, o_miss);
    end
    gq.push_back(8'h11);
    run_round(1'b0);
  endtask

  task automatic test_saturation();
    sel = 1'b1;
    for (int i = 0; i < 128; i++) rom_b[i] = 8'($urandom_range(0, 255));
    do_reset();
    press();
    repeat (110) begin
      gq.push_back(rom_b[m_addr]);
      run_round(1'b0);
    end
    checks++;
    if ({o_rd, o_ru} !== {4'd9, 4'd9}) begin
      errors++;
      $display("FAIL saturate got %0d%0d want 99", o_rd, o_ru);
    end
    sel = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom_a[i] = 8'h00;
    for (int i = 0; i < 128; i++) rom_b[i] = 8'h00;
    sel = 1'b0;
    iRst = 1'b1;
    iGo = 1'b0;
    iSW = 8'h00;
    test_reset();
    test_hit();
    test_miss();
    test_full_game();
    test_random_game();
    test_ignored_go();
    test_reset_in_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
